// File: rtl/mlp_layer_sequencer_if.sv
// rtl/mlp_layer_sequencer_if.sv - control, memory-read and result handshake bundle for the MLP layer sequencer
interface mlp_layer_sequencer_if #(
   parameter int DW       = 16,
   parameter int NEURON_W = 8,
   parameter int IDX_W    = 10
);
   logic                      start;
   logic [IDX_W:0]            cfg_n_in;
   logic [NEURON_W:0]         cfg_n_out;
   logic                      cfg_relu;
   logic                      busy;
   logic                      done;
   logic                      w_rd_en;
   logic [NEURON_W+IDX_W-1:0] w_addr;
   logic [DW-1:0]             w_rdata;
   logic                      x_rd_en;
   logic [IDX_W-1:0]          x_addr;
   logic [DW-1:0]             x_rdata;
   logic                      b_rd_en;
   logic [NEURON_W-1:0]       b_addr;
   logic [DW-1:0]             b_rdata;
   logic                      y_valid;
   logic                      y_ready;
   logic [NEURON_W-1:0]       y_addr;
   logic [DW-1:0]             y_data;

   modport master (
      input  start, cfg_n_in, cfg_n_out, cfg_relu, w_rdata, x_rdata, b_rdata, y_ready,
      output busy, done, w_rd_en, w_addr, x_rd_en, x_addr, b_rd_en, b_addr, y_valid, y_addr, y_data
   );

   modport slave (
      output start, cfg_n_in, cfg_n_out, cfg_relu, w_rdata, x_rdata, b_rdata, y_ready,
      input  busy, done, w_rd_en, w_addr, x_rd_en, x_addr, b_rd_en, b_addr, y_valid, y_addr, y_data
   );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - one fully-connected layer through a single shared Q8.8 multiply-accumulate
module mlp_layer_sequencer #(
   parameter int DW       = 16,
   parameter int FRAC     = 8,
   parameter int ACC_W    = 32,
   parameter int NEURON_W = 8,
   parameter int IDX_W    = 10
) (
   input logic                  clk,
   input logic                  rst_n,
   mlp_layer_sequencer_if.master bus
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DW - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

   state_t                    r_state;
   state_t                    w_next;
   logic [NEURON_W-1:0]       r_neuron;
   logic [IDX_W-1:0]          r_idx;
   logic [IDX_W:0]            r_n_in;
   logic [NEURON_W:0]         r_n_out;
   logic                      r_relu;
   logic                      r_drain;
   logic                      r_rd_vld;
   logic                      r_b_vld;
   logic                      r_p_vld;
   logic signed [ACC_W-1:0]   r_p;
   logic signed [ACC_W-1:0]   r_acc;
   logic [NEURON_W+IDX_W-1:0] r_w_addr;
   logic [IDX_W-1:0]          r_x_addr;
   logic [NEURON_W-1:0]       r_b_addr;

   logic                      w_start_ok;
   logic                      w_cfg_zero;
   logic                      w_last_idx;
   logic                      w_last_neuron;
   logic                      w_busy;
   logic                      w_done;
   logic                      w_rd_en;
   logic                      w_b_rd_en;
   logic                      w_y_valid;
   logic signed [2*DW-1:0]    w_prod;
   logic signed [2*DW-1:0]    w_prod_sh;
   logic signed [ACC_W-1:0]   w_p_ext;
   logic signed [ACC_W-1:0]   w_b_ext;
   logic signed [DW-1:0]      w_sat;
   logic [DW-1:0]             w_act;

   // start is masked by reset so every output reads 0 while rst_n is low
   assign w_start_ok    = bus.start & rst_n;
   assign w_cfg_zero    = (bus.cfg_n_in == '0) || (bus.cfg_n_out == '0);
   assign w_last_idx    = ({1'b0, r_idx} == (r_n_in - (IDX_W+1)'(1)));
   assign w_last_neuron = ({1'b0, r_neuron} == (r_n_out - (NEURON_W+1)'(1)));

   // full-width signed product, truncated back to Q8.8 by an arithmetic shift
   assign w_prod    = (2*DW)'($signed(bus.w_rdata)) * (2*DW)'($signed(bus.x_rdata));
   assign w_prod_sh = w_prod >>> FRAC;
   assign w_p_ext   = ACC_W'(w_prod_sh);
   assign w_b_ext   = ACC_W'($signed(bus.b_rdata));

   assign w_sat = (r_acc > SAT_MAX) ? SAT_MAX[DW-1:0] :
                  (r_acc < SAT_MIN) ? SAT_MIN[DW-1:0] : r_acc[DW-1:0];
   assign w_act = (r_relu && w_sat[DW-1]) ? '0 : w_sat;

   // next-state and per-state strobes
   always_comb begin
      w_next    = r_state;
      w_busy    = 1'b0;
      w_done    = 1'b0;
      w_rd_en   = 1'b0;
      w_b_rd_en = 1'b0;
      w_y_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_busy = 1'b1;
               w_next = w_cfg_zero ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_busy    = 1'b1;
            w_rd_en   = 1'b1;
            w_b_rd_en = (r_idx == '0);
            if (w_last_idx) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (r_drain) w_next = S_WRITE;
         end
         S_WRITE: begin
            w_busy    = 1'b1;
            w_y_valid = 1'b1;
            if (bus.y_ready) w_next = w_last_neuron ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // state, configuration latch and neuron/idx walk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_neuron <= '0;
         r_idx    <= '0;
         r_n_in   <= '0;
         r_n_out  <= '0;
         r_relu   <= 1'b0;
         r_drain  <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_start_ok && !w_cfg_zero) begin
                  r_n_in   <= bus.cfg_n_in;
                  r_n_out  <= bus.cfg_n_out;
                  r_relu   <= bus.cfg_relu;
                  r_neuron <= '0;
                  r_idx    <= '0;
               end
            end
            S_ISSUE: r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
            S_DRAIN: r_drain <= ~r_drain;
            S_WRITE: if (bus.y_ready && !w_last_neuron) r_neuron <= r_neuron + 1'b1;
            default: ;
         endcase
      end
   end

   // read addresses hold their last issued value while the enables are low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w_addr <= '0;
         r_x_addr <= '0;
         r_b_addr <= '0;
      end else begin
         if (w_rd_en) begin
            r_w_addr <= {r_neuron, r_idx};
            r_x_addr <= r_idx;
         end
         if (w_b_rd_en) r_b_addr <= r_neuron;
      end
   end

   // two-stage MAC: product register, then accumulate; bias seeds acc before the first product lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld <= 1'b0;
         r_b_vld  <= 1'b0;
         r_p_vld  <= 1'b0;
         r_p      <= '0;
         r_acc    <= '0;
      end else begin
         r_rd_vld <= w_rd_en;
         r_b_vld  <= w_b_rd_en;
         r_p_vld  <= r_rd_vld;
         if (r_rd_vld) r_p <= w_p_ext;
         if (r_b_vld)      r_acc <= w_b_ext;
         else if (r_p_vld) r_acc <= r_acc + r_p;
      end
   end

   assign bus.busy    = w_busy;
   assign bus.done    = w_done;
   assign bus.w_rd_en = w_rd_en;
   assign bus.x_rd_en = w_rd_en;
   assign bus.b_rd_en = w_b_rd_en;
   assign bus.w_addr  = w_rd_en ? {r_neuron, r_idx} : r_w_addr;
   assign bus.x_addr  = w_rd_en ? r_idx : r_x_addr;
   assign bus.b_addr  = w_b_rd_en ? r_neuron : r_b_addr;
   assign bus.y_valid = w_y_valid;
   assign bus.y_addr  = w_y_valid ? r_neuron : '0;
   assign bus.y_data  = w_y_valid ? w_act : '0;

endmodule
